text_console: RTL and testbench
===============================

Name: text_console

Overview:
- Sequencing controller for the character VRAM's write port: turns a byte stream from the CPU into VRAM writes at a managed cursor.
- Handles control codes, screen clear and hardware scroll by driving VRAM port A (single port, read/write). The LCD renderer keeps port B.
- Grid is 60x17 characters (480x272 panel, 8x16 glyphs); VRAM address = col + row*COLS.

Parameters:
- COLS, 60, characters per row.
- ROWS, 17, character rows; COLS*ROWS must be <= 1024.
- BLANK, 8'h20, fill code used by clear and scroll.

Ports:
- Clk  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- char_valid  in  1  char_data holds a byte to consume.
- char_data  in  8  character or control code.
- char_ready  out  1  block accepts char_data this cycle.
- clear_req  in  1  single-cycle pulse requesting a full-screen clear.
- v_cea  out  1  VRAM port A write enable.
- v_ada  out  10  VRAM port A address.
- v_dina  out  8  VRAM port A write data.
- v_douta  in  8  VRAM port A read data, 1-cycle latency after v_ada.
- cursor_col  out  6  current column.
- cursor_row  out  5  current row.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values while RST is high: v_cea=0, v_ada=0, v_dina=BLANK, cursor 0/0, char_ready=0, busy=1, state=CLR_ALL with counter 0.
- After reset release, the block auto-clears the whole screen before reaching IDLE.
- Handshake:
  - char_ready = (state==IDLE) && !clear_req.
  - A transfer occurs when char_valid && char_ready.
  - char_data is sampled once per transfer.
- Priority: clear_req beats a same-cycle char; that char is not accepted. clear_req received while busy is latched and serviced on the next IDLE.
- FSM states:
  - IDLE: wait for a transfer or a latched/current clear_req.
  - PUT: one-cycle write. v_cea=1, v_ada=col+row*COLS, v_dina=char. Then col+1.
  - SCR_RD / SCR_WR: alternate for src=COLS..COLS*ROWS-1. SCR_RD drives v_ada=src with v_cea=0. SCR_WR drives v_ada=src-COLS, v_dina=v_douta, v_cea=1. This costs 2 cycles per cell (1920 cycles at default).
  - SCR_BLANK: writes BLANK to the last row (COLS cycles), then returns to IDLE.
  - CLR_ALL: writes BLANK to addresses 0..COLS*ROWS-1 (1020 cycles), sets cursor to 0/0, then returns to IDLE.
- Control codes; every other code 0x00-0xFF goes through PUT:
  - 0x0A newline: col=0. If row<ROWS-1, row+1 (1 cycle). Otherwise enter scroll and keep row=ROWS-1.
  - 0x0D carriage return: col=0. No VRAM write.
  - 0x08 backspace: if col>0, col-1 and write BLANK at the new position. At col=0 nothing happens; it never moves up a row.
  - 0x0C form feed: same as clear_req.
- Column overflow after PUT at col=COLS-1: see Optional Feature.
- Arithmetic: address computed at 10 bits with no wrap. Scroll addresses never exceed COLS*ROWS-1.
- Reset mid-scroll or mid-clear: abort immediately and restart CLR_ALL. No partial VRAM state is guaranteed.
- cursor_col/cursor_row update in the cycle a control code or PUT completes.

Optional Feature:
- Macro TEXT_CONSOLE_AUTOWRAP_EN.
- Defined: a PUT at col=COLS-1 behaves as PUT followed by newline. It wraps to the next row and scrolls if already on the last row.
- Undefined: col saturates at COLS-1, so later printable chars overwrite the last column until CR, LF or clear.

Decomposition:
- Shared package console_pkg holds:
  - COLS_DEF=60, ROWS_DEF=17, BLANK_DEF.
  - Control-code constants CH_LF, CH_CR, CH_BS, CH_FF.
  - FSM enum console_state_t {IDLE, PUT, SCR_RD, SCR_WR, SCR_BLANK, CLR_ALL}.
- Sub-module vram_fill_engine:
  - Takes a start address, count, data and go; returns done.
  - Reused by CLR_ALL and SCR_BLANK.
  - The scroll copy stays in the top level.

Test Plan:
- Reset release with a VRAM model → exactly 1020 writes of 0x20, addresses 0..1019. Then busy=0, char_ready=1, cursor 0/0.
- Send 'A' (0x41) then 'B' → VRAM[0]=0x41, VRAM[1]=0x42, cursor_col=2. Each transfer costs one write cycle.
- Fill row r with "0x30+r", set cursor to row 16, send 0x0A → VRAM[0..59]=0x31 and the last row is all 0x20. busy lasts 1920+60 cycles; cursor 0/16.
- Send 'X' then 0x08 at col 1 → VRAM[0]=0x20, col=0. A second 0x08 causes no write and col stays 0.
- 61 chars at row 0: with TEXT_CONSOLE_AUTOWRAP_EN the 61st lands at VRAM[60], cursor 1/1. Without it the 61st lands at VRAM[59] and col stays 59.
- clear_req in the same cycle as char_valid during IDLE → char not accepted and CLR_ALL starts. Assert RST mid-scroll → v_cea=0 at once, then a full clear after release.

Source files
------------

// File: rtl/console_pkg.sv
// Shared definitions for the text console: grid defaults, control codes,
// the sequencing FSM state type and the cell address helper.
package console_pkg;

    localparam int         COLS_DEF  = 60;
    localparam int         ROWS_DEF  = 17;
    localparam logic [7:0] BLANK_DEF = 8'h20;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        SCR_RD,
        SCR_WR,
        SCR_BLANK,
        CLR_ALL
    } console_state_t;

    // Linear VRAM address of a character cell, 10 bits, no wrap.
    function automatic logic [9:0] cell_addr(input logic [5:0] col,
                                             input logic [4:0] row,
                                             input logic [9:0] cols);
        return {4'd0, col} + ({5'd0, row} * cols);
    endfunction

endpackage

// File: rtl/vram_fill_engine.sv
// Sequential fill engine: on go, writes fill_data to count consecutive VRAM
// addresses starting at start_addr, one per cycle. done is high during the
// final write cycle so the caller can leave its state on the same edge.
module vram_fill_engine
    import console_pkg::*;
#(
    parameter logic [7:0] BLANK = BLANK_DEF
) (
    input  logic        Clk,
    input  logic        RST,
    input  logic        go,
    input  logic [9:0]  start_addr,
    input  logic [10:0] count,
    input  logic [7:0]  fill_data,
    output logic        we,
    output logic [9:0]  addr,
    output logic [7:0]  data,
    output logic        done
);

    logic        active_reg;
    logic [9:0]  addr_reg;
    logic [10:0] remain_reg;
    logic [7:0]  data_reg;

    // Load a new run on go, otherwise step through the run one cell per cycle.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            active_reg <= 1'b0;
            addr_reg   <= 10'd0;
            remain_reg <= 11'd0;
            data_reg   <= BLANK;
        end else if (go && !active_reg) begin
            active_reg <= (count != 11'd0);
            addr_reg   <= start_addr;
            remain_reg <= count;
            data_reg   <= fill_data;
        end else if (active_reg) begin
            addr_reg   <= addr_reg + 10'd1;
            remain_reg <= remain_reg - 11'd1;
            if (remain_reg == 11'd1) begin
                active_reg <= 1'b0;
            end
        end
    end

    assign we   = active_reg;
    assign addr = addr_reg;
    assign data = data_reg;
    assign done = active_reg && (remain_reg == 11'd1);

endmodule

// File: rtl/text_console.sv
// Text console write-port sequencer: turns a CPU byte stream into character
// VRAM writes at a managed cursor, with control codes, clear and scroll.
// Build option: define TEXT_CONSOLE_AUTOWRAP_EN to wrap (and scroll) after a
// character is written in the last column; otherwise the column saturates.
module text_console
    import console_pkg::*;
#(
    parameter int         COLS  = COLS_DEF,
    parameter int         ROWS  = ROWS_DEF,
    parameter logic [7:0] BLANK = BLANK_DEF
) (
    input  logic       Clk,
    input  logic       RST,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       v_cea,
    output logic [9:0] v_ada,
    output logic [7:0] v_dina,
    input  logic [7:0] v_douta,
    output logic [5:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic       busy
);

    localparam logic [9:0]  COLS_A        = 10'(COLS);
    localparam logic [9:0]  LAST_ADDR     = 10'(COLS * ROWS - 1);
    localparam logic [9:0]  LAST_ROW_ADDR = 10'((ROWS - 1) * COLS);
    localparam logic [10:0] CELLS         = 11'(COLS * ROWS);
    localparam logic [10:0] ROW_CELLS     = 11'(COLS);
    localparam logic [5:0]  LAST_COL      = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);

    console_state_t state_reg;
    logic [5:0] col_reg;
    logic [4:0] row_reg;
    logic [7:0] char_reg;
    logic       bs_reg;
    logic [9:0] src_reg;
    logic       pending_clear_reg;
    logic       boot_reg;

    logic       take;
    logic       clear_now;
    logic       scroll_last;
    logic [5:0] put_col;
    logic [9:0] put_addr;

    logic        fill_go;
    logic [9:0]  fill_start;
    logic [10:0] fill_count;
    logic        fill_we;
    logic [9:0]  fill_addr;
    logic [7:0]  fill_wdata;
    logic        fill_done;

    assign char_ready = (state_reg == IDLE) && !clear_req;
    assign busy       = (state_reg != IDLE);
    assign take       = char_valid && char_ready;
    // A pending clear also wins over a char offered in the same IDLE cycle;
    // that char is swallowed because the screen is about to be wiped.
    assign clear_now  = (state_reg == IDLE) &&
                        (clear_req || pending_clear_reg || (take && char_data == CH_FF));
    assign scroll_last = (state_reg == SCR_WR) && (src_reg == LAST_ADDR);

    // Backspace writes one cell to the left of the cursor.
    assign put_col  = bs_reg ? (col_reg - 6'd1) : col_reg;
    assign put_addr = cell_addr(put_col, row_reg, COLS_A);

    // The fill engine is started on the edge that enters CLR_ALL/SCR_BLANK
    // so its writes line up with the state; after reset CLR_ALL kicks it once.
    assign fill_go    = clear_now || (state_reg == CLR_ALL && boot_reg) || scroll_last;
    assign fill_start = scroll_last ? LAST_ROW_ADDR : 10'd0;
    assign fill_count = scroll_last ? ROW_CELLS : CELLS;

    vram_fill_engine #(
        .BLANK (BLANK)
    ) u_fill (
        .Clk        (Clk),
        .RST        (RST),
        .go         (fill_go),
        .start_addr (fill_start),
        .count      (fill_count),
        .fill_data  (BLANK),
        .we         (fill_we),
        .addr       (fill_addr),
        .data       (fill_wdata),
        .done       (fill_done)
    );

    // Port A drive: fill engine when active, else the PUT/scroll-copy access.
    always_comb begin
        v_cea  = 1'b0;
        v_ada  = 10'd0;
        v_dina = BLANK;
        if (fill_we) begin
            v_cea  = 1'b1;
            v_ada  = fill_addr;
            v_dina = fill_wdata;
        end else begin
            case (state_reg)
                PUT: begin
                    v_cea  = 1'b1;
                    v_ada  = put_addr;
                    v_dina = char_reg;
                end
                SCR_RD: begin
                    v_ada = src_reg;
                end
                SCR_WR: begin
                    v_cea  = 1'b1;
                    v_ada  = src_reg - COLS_A;
                    v_dina = v_douta;
                end
                default: begin
                end
            endcase
        end
    end

    // Sequencing FSM: cursor, pending clear, scroll source counter.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            state_reg         <= CLR_ALL;
            col_reg           <= 6'd0;
            row_reg           <= 5'd0;
            char_reg          <= BLANK;
            bs_reg            <= 1'b0;
            src_reg           <= 10'd0;
            pending_clear_reg <= 1'b0;
            boot_reg          <= 1'b1;
        end else begin
            if (clear_req && state_reg != IDLE) begin
                pending_clear_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (clear_now) begin
                        pending_clear_reg <= 1'b0;
                        state_reg         <= CLR_ALL;
                    end else if (take) begin
                        case (char_data)
                            CH_LF: begin
                                col_reg <= 6'd0;
                                if (row_reg < LAST_ROW) begin
                                    row_reg <= row_reg + 5'd1;
                                end else begin
                                    src_reg   <= COLS_A;
                                    state_reg <= SCR_RD;
                                end
                            end
                            CH_CR: begin
                                col_reg <= 6'd0;
                            end
                            CH_BS: begin
                                if (col_reg != 6'd0) begin
                                    bs_reg    <= 1'b1;
                                    char_reg  <= BLANK;
                                    state_reg <= PUT;
                                end
                            end
                            default: begin
                                bs_reg    <= 1'b0;
                                char_reg  <= char_data;
                                state_reg <= PUT;
                            end
                        endcase
                    end
                end
                PUT: begin
                    state_reg <= IDLE;
                    if (bs_reg) begin
                        col_reg <= col_reg - 6'd1;
                    end else if (col_reg != LAST_COL) begin
                        col_reg <= col_reg + 6'd1;
                    end else begin
`ifdef TEXT_CONSOLE_AUTOWRAP_EN
                        col_reg <= 6'd0;
                        if (row_reg < LAST_ROW) begin
                            row_reg <= row_reg + 5'd1;
                        end else begin
                            src_reg   <= COLS_A;
                            state_reg <= SCR_RD;
                        end
`else
                        col_reg <= LAST_COL;
`endif
                    end
                end
                SCR_RD: begin
                    state_reg <= SCR_WR;
                end
                SCR_WR: begin
                    if (scroll_last) begin
                        state_reg <= SCR_BLANK;
                    end else begin
                        src_reg   <= src_reg + 10'd1;
                        state_reg <= SCR_RD;
                    end
                end
                SCR_BLANK: begin
                    if (fill_done) begin
                        state_reg <= IDLE;
                    end
                end
                CLR_ALL: begin
                    boot_reg <= 1'b0;
                    if (fill_done) begin
                        col_reg   <= 6'd0;
                        row_reg   <= 5'd0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cursor_col = col_reg;
    assign cursor_row = row_reg;

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: VRAM model on port A plus a screen/cursor reference
// model computed from the console rules; directed scenarios then random bytes.
module tb_text_console;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready;
    logic       clear_req = 1'b0;
    logic       v_cea;
    logic [9:0] v_ada;
    logic [7:0] v_dina;
    logic [7:0] v_douta = 8'h00;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] vram [0:1023];
    logic [7:0] exp_mem [0:1019];
    int ec = 0;
    int er = 0;
    int wq_a[$];
    int wq_d[$];

    always #5 clk = ~clk;

    text_console dut (
        .Clk        (clk),
        .RST        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .v_cea      (v_cea),
        .v_ada      (v_ada),
        .v_dina     (v_dina),
        .v_douta    (v_douta),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    // VRAM port A: registered read of the old contents, write logged.
    always @(posedge clk) begin
        v_douta <= vram[v_ada];
        if (v_cea) begin
            vram[v_ada] = v_dina;
            wq_a.push_back(int'(v_ada));
            wq_d.push_back(int'(v_dina));
        end
    end

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int i = 0; i < 1020; i++) exp_mem[i] = 8'h20;
        ec = 0;
        er = 0;
    endtask

    task automatic model_newline();
        ec = 0;
        if (er < 16) er++;
        else begin
            for (int i = 0; i < 960; i++) exp_mem[i] = exp_mem[i + 60];
            for (int i = 960; i < 1020; i++) exp_mem[i] = 8'h20;
        end
    endtask

    task automatic model_char(input logic [7:0] b);
        case (b)
            8'h0C: model_clear();
            8'h0A: model_newline();
            8'h0D: ec = 0;
            8'h08: if (ec > 0) begin ec--; exp_mem[er * 60 + ec] = 8'h20; end
            default: begin
                exp_mem[er * 60 + ec] = b;
                if (ec < 59) ec++;
                else begin
`ifdef TEXT_CONSOLE_AUTOWRAP_EN
                    model_newline();
`endif
                end
            end
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (busy) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic send_char(input logic [7:0] b, output int cyc);
        int n = 0;
        while (!char_ready && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!char_ready) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: char_ready=%0b, required 1", char_ready);
        end
        char_valid = 1'b1;
        char_data  = b;
        @(posedge clk); #1;
        char_valid = 1'b0;
        model_char(b);
        wait_idle(cyc);
        $display("tx %02h -> cursor %0d/%0d busy_cycles %0d", b, cursor_col, cursor_row, cyc);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int cyc;
        int bad = 0;
        for (int i = 0; i < 1024; i++) vram[i] = 8'hFF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (v_cea !== 1'b0 || v_ada !== 10'd0 || v_dina !== 8'h20 || char_ready !== 1'b0 ||
            busy !== 1'b1 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            mismatched++;
            $display("FAIL reset_values: cea=%0b ada=%0d dina=%h ready=%0b busy=%0b cur=%0d/%0d, required 0 0 20 0 1 0/0",
                     v_cea, v_ada, v_dina, char_ready, busy, cursor_col, cursor_row);
        end
        wq_a.delete(); wq_d.delete();
        rst = 1'b0;
        wait_idle(cyc);
        model_clear();
        if (wq_a.size() == 1020)
            for (int i = 0; i < 1020; i++) if (wq_a[i] != i || wq_d[i] != 32) bad++;
        compared++;
        if (wq_a.size() != 1020 || bad != 0) begin
            mismatched++;
            $display("FAIL boot_clear: writes=%0d bad=%0d, required 1020 writes of 20 at 0..1019", wq_a.size(), bad);
        end
        compared++;
        if (busy !== 1'b0 || char_ready !== 1'b1 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            mismatched++;
            $display("FAIL boot_idle: busy=%0b ready=%0b cur=%0d/%0d, required 0 1 0/0",
                     busy, char_ready, cursor_col, cursor_row);
        end
    endtask

    task automatic test_put();
        int cyc;
        wq_a.delete(); wq_d.delete();
        send_char(8'h41, cyc);
        compared++;
        if (cyc != 1 || wq_a.size() != 1 || vram[0] !== 8'h41) begin
            mismatched++;
            $display("FAIL put_A: cycles=%0d writes=%0d vram0=%h, required 1 1 41", cyc, wq_a.size(), vram[0]);
        end
        send_char(8'h42, cyc);
        compared++;
        if (cyc != 1 || vram[1] !== 8'h42 || cursor_col !== 6'd2 || cursor_row !== 5'd0) begin
            mismatched++;
            $display("FAIL put_B: cycles=%0d vram1=%h cur=%0d/%0d, required 1 42 2/0",
                     cyc, vram[1], cursor_col, cursor_row);
        end
    endtask

    task automatic test_scroll();
        int cyc;
        int bad = 0;
        send_char(8'h0C, cyc);
        for (int r = 0; r < 17; r++)
            for (int c = 0; c < 60; c++) begin
                vram[r * 60 + c]    = 8'(8'h30 + r);
                exp_mem[r * 60 + c] = 8'(8'h30 + r);
            end
        for (int i = 0; i < 16; i++) send_char(8'h0A, cyc);
        compared++;
        if (cursor_row !== 5'd16 || cursor_col !== 6'd0) begin
            mismatched++;
            $display("FAIL lf_rows: cur=%0d/%0d, required 0/16", cursor_col, cursor_row);
        end
        wq_a.delete(); wq_d.delete();
        send_char(8'h0A, cyc);
        compared++;
        if (cyc != 1980 || wq_a.size() != 1020) begin
            mismatched++;
            $display("FAIL scroll_timing: busy_cycles=%0d writes=%0d, required 1980 1020", cyc, wq_a.size());
        end
        for (int c = 0; c < 60; c++) begin
            if (vram[c] !== 8'h31) bad++;
            if (vram[960 + c] !== 8'h20) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL scroll_rows: bad_cells=%0d, required row0=31 last_row=20", bad);
        end
        bad = 0;
        for (int i = 0; i < 1020; i++) if (vram[i] !== exp_mem[i]) bad++;
        compared++;
        if (bad != 0 || cursor_col !== 6'd0 || cursor_row !== 5'd16) begin
            mismatched++;
            $display("FAIL scroll_screen: bad_cells=%0d cur=%0d/%0d, required 0 0/16", bad, cursor_col, cursor_row);
        end
    endtask

    task automatic test_backspace();
        int cyc;
        send_char(8'h0C, cyc);
        send_char(8'h58, cyc);
        wq_a.delete(); wq_d.delete();
        send_char(8'h08, cyc);
        compared++;
        if (cyc != 1 || wq_a.size() != 1 || vram[0] !== 8'h20 || cursor_col !== 6'd0) begin
            mismatched++;
            $display("FAIL bs_first: cycles=%0d writes=%0d vram0=%h col=%0d, required 1 1 20 0",
                     cyc, wq_a.size(), vram[0], cursor_col);
        end
        wq_a.delete(); wq_d.delete();
        send_char(8'h08, cyc);
        compared++;
        if (cyc != 0 || wq_a.size() != 0 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            mismatched++;
            $display("FAIL bs_col0: cycles=%0d writes=%0d cur=%0d/%0d, required 0 0 0/0",
                     cyc, wq_a.size(), cursor_col, cursor_row);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        send_char(8'h0C, cyc);
        for (int i = 0; i < 61; i++) send_char(8'(8'h41 + (i % 26)), cyc);
        compared++;
`ifdef TEXT_CONSOLE_AUTOWRAP_EN
        if (vram[60] !== 8'h49 || vram[59] !== 8'h48 || cursor_col !== 6'd1 || cursor_row !== 5'd1) begin
            mismatched++;
            $display("FAIL wrap_on: vram59=%h vram60=%h cur=%0d/%0d, required 48 49 1/1",
                     vram[59], vram[60], cursor_col, cursor_row);
        end
`else
        if (vram[59] !== 8'h49 || vram[60] !== 8'h20 || cursor_col !== 6'd59 || cursor_row !== 5'd0) begin
            mismatched++;
            $display("FAIL wrap_off: vram59=%h vram60=%h cur=%0d/%0d, required 49 20 59/0",
                     vram[59], vram[60], cursor_col, cursor_row);
        end
`endif
    endtask

    task automatic test_clear_priority();
        int cyc;
        int bad = 0;
        send_char(8'h51, cyc);
        char_valid = 1'b1;
        char_data  = 8'h5A;
        clear_req  = 1'b1;
        #1;
        compared++;
        if (char_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL clr_ready: char_ready=%0b, required 0", char_ready);
        end
        @(posedge clk); #1;
        char_valid = 1'b0;
        clear_req  = 1'b0;
        compared++;
        if (busy !== 1'b1 || v_cea !== 1'b1 || v_ada !== 10'd0 || v_dina !== 8'h20) begin
            mismatched++;
            $display("FAIL clr_start: busy=%0b cea=%0b ada=%0d dina=%h, required 1 1 0 20",
                     busy, v_cea, v_ada, v_dina);
        end
        wait_idle(cyc);
        model_clear();
        for (int i = 0; i < 1020; i++) if (vram[i] !== 8'h20) bad++;
        compared++;
        if (bad != 0 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            mismatched++;
            $display("FAIL clr_result: non_blank=%0d cur=%0d/%0d, required 0 0/0", bad, cursor_col, cursor_row);
        end
    endtask

    task automatic test_latched_clear();
        int cyc;
        int bad = 0;
        while (!char_ready) begin @(posedge clk); #1; end
        char_valid = 1'b1;
        char_data  = 8'h4B;
        @(posedge clk); #1;
        char_valid = 1'b0;
        clear_req  = 1'b1;
        @(posedge clk); #1;
        clear_req  = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL latched_clear: busy=%0b, required 1", busy);
        end
        wait_idle(cyc);
        model_clear();
        for (int i = 0; i < 1020; i++) if (vram[i] !== 8'h20) bad++;
        compared++;
        if (bad != 0 || cursor_col !== 6'd0) begin
            mismatched++;
            $display("FAIL latched_result: non_blank=%0d col=%0d, required 0 0", bad, cursor_col);
        end
    endtask

    task automatic test_reset_mid_scroll();
        int cyc;
        int n = 0;
        int bad = 0;
        for (int i = 0; i < 16; i++) send_char(8'h0A, cyc);
        send_char(8'h4D, cyc);
        char_valid = 1'b1;
        char_data  = 8'h0A;
        @(posedge clk); #1;
        char_valid = 1'b0;
        repeat (101) @(posedge clk);
        #1;
        while (!v_cea && n < 10) begin @(posedge clk); #1; n++; end
        rst = 1'b1;
        #1;
        compared++;
        if (v_cea !== 1'b0 || busy !== 1'b1 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            mismatched++;
            $display("FAIL rst_mid_scroll: cea=%0b busy=%0b cur=%0d/%0d, required 0 1 0/0",
                     v_cea, busy, cursor_col, cursor_row);
        end
        @(posedge clk); #1;
        wq_a.delete(); wq_d.delete();
        rst = 1'b0;
        wait_idle(cyc);
        model_clear();
        for (int i = 0; i < 1020; i++) if (vram[i] !== 8'h20) bad++;
        compared++;
        if (wq_a.size() != 1020 || bad != 0) begin
            mismatched++;
            $display("FAIL rst_reclear: writes=%0d non_blank=%0d, required 1020 0", wq_a.size(), bad);
        end
    endtask

    task automatic test_random();
        int cyc;
        int bad;
        int r;
        logic [7:0] b;
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 99);
            if (r < 8) b = 8'h0A;
            else if (r < 12) b = 8'h0D;
            else if (r < 22) b = 8'h08;
            else if (r < 23) b = 8'h0C;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h0A || b == 8'h0D || b == 8'h08 || b == 8'h0C) b = 8'h7E;
            end
            send_char(b, cyc);
            bad = 0;
            for (int i = 0; i < 1020; i++) if (vram[i] !== exp_mem[i]) bad++;
            compared++;
            if (bad != 0 || int'(cursor_col) != ec || int'(cursor_row) != er) begin
                mismatched++;
                $display("FAIL random_%0d: data=%h bad_cells=%0d cur=%0d/%0d, required 0 %0d/%0d",
                         t, b, bad, cursor_col, cursor_row, ec, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_put();
        test_scroll();
        test_backspace();
        test_wrap();
        test_clear_priority();
        test_latched_clear();
        test_reset_mid_scroll();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
